// File: rtl/riscv_decode_stage_pkg.sv
// Shared RV32 decode definitions: opcodes, immediate formats, decoded bundle
// and the funct3/funct7 legality tables used by the decoder.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      imm_type_e   imm_type;
      logic        is_load;
      logic        is_store;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        is_lui;
      logic        is_auipc;
      logic        is_op;
      logic        is_op_imm;
      logic        is_muldiv;
      logic        is_fence;
      logic        is_system;
      logic        is_csr;
      logic        rd_we;
      logic        rs1_used;
      logic        rs2_used;
      logic        illegal;
   } dec_t;

   function automatic logic legal_load_f3(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
             (f3 == 3'b100) || (f3 == 3'b101);
   endfunction

   function automatic logic legal_store_f3(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
   endfunction

   function automatic logic legal_branch_f3(input logic [2:0] f3);
      return (f3 != 3'b010) && (f3 != 3'b011);
   endfunction

   function automatic logic legal_fence_f3(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001);
   endfunction

   // SUB/SRA only exist as the alternate encoding of ADD/SRL
   function automatic logic legal_op_f7(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic en_m);
      logic ok;
      case (f7)
         F7_BASE:   ok = 1'b1;
         F7_ALT:    ok = (f3 == 3'b000) || (f3 == 3'b101);
         F7_MULDIV: ok = en_m;
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Only the shift-immediate forms constrain funct7
   function automatic logic legal_op_imm_f7(input logic [2:0] f3, input logic [6:0] f7);
      logic ok;
      case (f3)
         3'b001:  ok = (f7 == F7_BASE);
         3'b101:  ok = (f7 == F7_BASE) || (f7 == F7_ALT);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] imm_sel(input logic [31:0] instr, input imm_type_e t);
      logic [31:0] imm;
      case (t)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'h000};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'h0000_0000;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/riscv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface riscv_decode_stage_if
   import riscv_pkg::*;
#(
   parameter int CNT_W = 16
) ();

   logic             flush_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [31:0]      in_instr_i;
   logic [31:0]      in_pc_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [31:0]      out_pc_o;
   dec_t             out_dec_o;
   logic [CNT_W-1:0] illegal_cnt_o;

   modport slave (
      input  flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
      output in_ready_o, out_valid_o, out_pc_o, out_dec_o, illegal_cnt_o
   );

   modport master (
      output flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_pc_o, out_dec_o, illegal_cnt_o
   );

endinterface

// File: rtl/riscv_decode_comb.sv
// Combinational RV32 instruction decoder: fields, immediate, category and legality.
module riscv_decode_comb
   import riscv_pkg::*;
#(
   parameter bit ENABLE_M   = 1'b0,
   parameter bit ENABLE_CSR = 1'b1
) (
   input  logic [31:0] instr,
   output dec_t        dec
);

   logic legal;

   // Decode by opcode, then strip categories and register usage from illegal words
   always_comb begin
      dec        = '0;
      legal      = 1'b0;
      dec.opcode = instr[6:0];
      dec.rd     = instr[11:7];
      dec.funct3 = instr[14:12];
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.funct7 = instr[31:25];
      case (instr[6:0])
         OPC_LOAD: begin
            dec.imm_type = IMM_I;
            legal        = legal_load_f3(instr[14:12]);
            dec.is_load  = 1'b1;
            dec.rd_we    = 1'b1;
            dec.rs1_used = 1'b1;
         end
         OPC_STORE: begin
            dec.imm_type = IMM_S;
            legal        = legal_store_f3(instr[14:12]);
            dec.is_store = 1'b1;
            dec.rs1_used = 1'b1;
            dec.rs2_used = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm_type  = IMM_B;
            legal         = legal_branch_f3(instr[14:12]);
            dec.is_branch = 1'b1;
            dec.rs1_used  = 1'b1;
            dec.rs2_used  = 1'b1;
         end
         OPC_JALR: begin
            dec.imm_type = IMM_I;
            legal        = (instr[14:12] == 3'b000);
            dec.is_jalr  = 1'b1;
            dec.rd_we    = 1'b1;
            dec.rs1_used = 1'b1;
         end
         OPC_JAL: begin
            dec.imm_type = IMM_J;
            legal        = 1'b1;
            dec.is_jal   = 1'b1;
            dec.rd_we    = 1'b1;
         end
         OPC_LUI: begin
            dec.imm_type = IMM_U;
            legal        = 1'b1;
            dec.is_lui   = 1'b1;
            dec.rd_we    = 1'b1;
         end
         OPC_AUIPC: begin
            dec.imm_type = IMM_U;
            legal        = 1'b1;
            dec.is_auipc = 1'b1;
            dec.rd_we    = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.imm_type  = IMM_I;
            legal         = legal_op_imm_f7(instr[14:12], instr[31:25]);
            dec.is_op_imm = 1'b1;
            dec.rd_we     = 1'b1;
            dec.rs1_used  = 1'b1;
         end
         OPC_OP: begin
            legal        = legal_op_f7(instr[14:12], instr[31:25], ENABLE_M);
            dec.is_muldiv = (instr[31:25] == F7_MULDIV);
            dec.is_op     = (instr[31:25] != F7_MULDIV);
            dec.rd_we     = 1'b1;
            dec.rs1_used  = 1'b1;
            dec.rs2_used  = 1'b1;
         end
         OPC_MISC_MEM: begin
            legal        = legal_fence_f3(instr[14:12]);
            dec.is_fence = 1'b1;
         end
         OPC_SYSTEM: begin
            if (instr[14:12] == 3'b000) begin
               legal         = (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
               dec.is_system = 1'b1;
            end else if (instr[14:12] == 3'b100) begin
               legal = 1'b0;
            end else begin
               // funct3[2] selects the immediate CSR forms, which read no register
               legal        = ENABLE_CSR;
               dec.is_csr   = 1'b1;
               dec.rd_we    = 1'b1;
               dec.rs1_used = ~instr[14];
            end
         end
         default: legal = 1'b0;
      endcase
      if (instr[1:0] != 2'b11) begin
         legal = 1'b0;
      end
      dec.imm = imm_sel(instr, dec.imm_type);
      if (!legal) begin
         dec.is_load   = 1'b0;
         dec.is_store  = 1'b0;
         dec.is_branch = 1'b0;
         dec.is_jal    = 1'b0;
         dec.is_jalr   = 1'b0;
         dec.is_lui    = 1'b0;
         dec.is_auipc  = 1'b0;
         dec.is_op     = 1'b0;
         dec.is_op_imm = 1'b0;
         dec.is_muldiv = 1'b0;
         dec.is_fence  = 1'b0;
         dec.is_system = 1'b0;
         dec.is_csr    = 1'b0;
         dec.rd_we     = 1'b0;
         dec.rs1_used  = 1'b0;
         dec.rs2_used  = 1'b0;
         dec.illegal   = 1'b1;
      end
      if (dec.rd == 5'd0) begin
         dec.rd_we = 1'b0;
      end
   end

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered decode stage: combinational decode captured into a main/skid
// register pair, plus a saturating counter of accepted illegal instructions.
module riscv_decode_stage
   import riscv_pkg::*;
#(
   parameter bit ENABLE_M   = 1'b0,
   parameter bit ENABLE_CSR = 1'b1,
   parameter int CNT_W      = 16
) (
   input logic                 clk_i,
   input logic                 rst_i,
   riscv_decode_stage_if.slave bus
);

   dec_t             dec_p0;
   logic             accept_p0;
   logic             drain_p1;
   logic             main_vld_p1;
   logic [31:0]      main_pc_p1;
   dec_t             main_dec_p1;
   logic             skid_vld_p1;
   logic [31:0]      skid_pc_p1;
   dec_t             skid_dec_p1;
   logic [CNT_W-1:0] cnt_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   riscv_decode_comb #(
      .ENABLE_M   (ENABLE_M),
      .ENABLE_CSR (ENABLE_CSR)
   ) u_decode (
      .instr (bus.in_instr_i),
      .dec   (dec_p0)
   );

   // ---- p0 -> p1: acceptance and drain qualifiers ----
   // Ready is derived purely from the skid register so it never waits on out_ready_i
   assign accept_p0 = bus.in_valid_i & ~skid_vld_p1 & ~bus.flush_i;
   assign drain_p1  = main_vld_p1 & bus.out_ready_i;

   // Main/skid buffer update; flush discards both entries and any same-cycle input
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_vld_p1 <= 1'b0;
         main_pc_p1  <= '0;
         main_dec_p1 <= '0;
         skid_vld_p1 <= 1'b0;
         skid_pc_p1  <= '0;
         skid_dec_p1 <= '0;
      end else if (bus.flush_i) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
      end else if (drain_p1) begin
         if (skid_vld_p1) begin
            main_pc_p1  <= skid_pc_p1;
            main_dec_p1 <= skid_dec_p1;
            skid_vld_p1 <= 1'b0;
         end else if (accept_p0) begin
            main_pc_p1  <= bus.in_pc_i;
            main_dec_p1 <= dec_p0;
         end else begin
            main_vld_p1 <= 1'b0;
         end
      end else if (!main_vld_p1) begin
         if (accept_p0) begin
            main_vld_p1 <= 1'b1;
            main_pc_p1  <= bus.in_pc_i;
            main_dec_p1 <= dec_p0;
         end
      end else if (accept_p0) begin
         skid_vld_p1 <= 1'b1;
         skid_pc_p1  <= bus.in_pc_i;
         skid_dec_p1 <= dec_p0;
      end
   end

   // Debug count of accepted illegal words; survives flush, cleared only by reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_p1 <= '0;
      end else if (accept_p0 && dec_p0.illegal) begin
         cnt_p1 <= sat_inc(cnt_p1);
      end
   end

   assign bus.in_ready_o    = ~skid_vld_p1;
   assign bus.out_valid_o   = main_vld_p1;
   assign bus.out_pc_o      = main_pc_p1;
   assign bus.out_dec_o     = main_dec_p1;
   assign bus.illegal_cnt_o = cnt_p1;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: directed scenarios plus randomized traffic
// against an instruction-table reference model and a two-deep queue model.
module tb_riscv_decode_stage;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   riscv_decode_stage_if #(.CNT_W(16)) bus0 ();
   riscv_decode_stage_if #(.CNT_W(3))  bus1 ();

   riscv_decode_stage #(.ENABLE_M(1'b0), .ENABLE_CSR(1'b1), .CNT_W(16)) dut (
      .clk_i (clk), .rst_i (rst), .bus (bus0));
   riscv_decode_stage #(.ENABLE_M(1'b1), .ENABLE_CSR(1'b1), .CNT_W(3)) dut_m (
      .clk_i (clk), .rst_i (rst), .bus (bus1));

   int checks = 0;
   int errors = 0;

   typedef enum {C_ILL, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST,
                 C_ALUI, C_ALU, C_MD, C_FENCE, C_SYS, C_CSR} cls_e;
   typedef struct {logic [31:0] pc; dec_t dec;} ent_t;

   ent_t        q0[$];
   ent_t        q1[$];
   int unsigned cnt0 = 0;
   int unsigned cnt1 = 0;

   logic [6:0] ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                            7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

   // Classify a word against the RV32I/M/Zicsr encoding table
   function automatic cls_e classify(input logic [31:0] w, input bit en_m);
      cls_e c = C_ILL;
      casez (w)
         32'b???????_?????_?????_???_?????_0110111: c = C_LUI;
         32'b???????_?????_?????_???_?????_0010111: c = C_AUIPC;
         32'b???????_?????_?????_???_?????_1101111: c = C_JAL;
         32'b???????_?????_?????_000_?????_1100111: c = C_JALR;
         32'b???????_?????_?????_00?_?????_1100011: c = C_BR;
         32'b???????_?????_?????_1??_?????_1100011: c = C_BR;
         32'b???????_?????_?????_00?_?????_0000011: c = C_LD;
         32'b???????_?????_?????_010_?????_0000011: c = C_LD;
         32'b???????_?????_?????_10?_?????_0000011: c = C_LD;
         32'b???????_?????_?????_00?_?????_0100011: c = C_ST;
         32'b???????_?????_?????_010_?????_0100011: c = C_ST;
         32'b???????_?????_?????_??0_?????_0010011: c = C_ALUI;
         32'b???????_?????_?????_?11_?????_0010011: c = C_ALUI;
         32'b0000000_?????_?????_001_?????_0010011: c = C_ALUI;
         32'b0?00000_?????_?????_101_?????_0010011: c = C_ALUI;
         32'b0000000_?????_?????_???_?????_0110011: c = C_ALU;
         32'b0100000_?????_?????_000_?????_0110011: c = C_ALU;
         32'b0100000_?????_?????_101_?????_0110011: c = C_ALU;
         32'b0000001_?????_?????_???_?????_0110011: if (en_m) c = C_MD;
         32'b???????_?????_?????_00?_?????_0001111: c = C_FENCE;
         32'h0000_0073, 32'h0010_0073:             c = C_SYS;
         32'b???????_?????_?????_001_?????_1110011: c = C_CSR;
         32'b???????_?????_?????_01?_?????_1110011: c = C_CSR;
         32'b???????_?????_?????_101_?????_1110011: c = C_CSR;
         32'b???????_?????_?????_11?_?????_1110011: c = C_CSR;
         default: c = C_ILL;
      endcase
      return c;
   endfunction

   function automatic dec_t exp_dec(input logic [31:0] w, input bit en_m);
      dec_t d;
      int   v;
      cls_e c;
      d = '0;
      v = 0;
      c = classify(w, en_m);
      d.opcode = w[6:0];
      d.rd     = w[11:7];
      d.funct3 = w[14:12];
      d.rs1    = w[19:15];
      d.rs2    = w[24:20];
      d.funct7 = w[31:25];
      case (w[6:0])
         7'h03, 7'h67, 7'h13: begin d.imm_type = IMM_I; v = int'($signed(w[31:20])); end
         7'h23: begin d.imm_type = IMM_S; v = int'($signed({w[31:25], w[11:7]})); end
         7'h63: begin d.imm_type = IMM_B; v = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
         7'h37, 7'h17: begin d.imm_type = IMM_U; v = int'({w[31:12], 12'h000}); end
         7'h6F: begin d.imm_type = IMM_J; v = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
         default: d.imm_type = IMM_NONE;
      endcase
      d.imm = v;
      case (c)
         C_LUI:   begin d.is_lui = 1'b1; d.rd_we = 1'b1; end
         C_AUIPC: begin d.is_auipc = 1'b1; d.rd_we = 1'b1; end
         C_JAL:   begin d.is_jal = 1'b1; d.rd_we = 1'b1; end
         C_JALR:  begin d.is_jalr = 1'b1; d.rd_we = 1'b1; d.rs1_used = 1'b1; end
         C_BR:    begin d.is_branch = 1'b1; d.rs1_used = 1'b1; d.rs2_used = 1'b1; end
         C_LD:    begin d.is_load = 1'b1; d.rd_we = 1'b1; d.rs1_used = 1'b1; end
         C_ST:    begin d.is_store = 1'b1; d.rs1_used = 1'b1; d.rs2_used = 1'b1; end
         C_ALUI:  begin d.is_op_imm = 1'b1; d.rd_we = 1'b1; d.rs1_used = 1'b1; end
         C_ALU:   begin d.is_op = 1'b1; d.rd_we = 1'b1; d.rs1_used = 1'b1; d.rs2_used = 1'b1; end
         C_MD:    begin d.is_muldiv = 1'b1; d.rd_we = 1'b1; d.rs1_used = 1'b1; d.rs2_used = 1'b1; end
         C_FENCE: d.is_fence = 1'b1;
         C_SYS:   d.is_system = 1'b1;
         C_CSR:   begin d.is_csr = 1'b1; d.rd_we = 1'b1; d.rs1_used = ~w[14]; end
         default: d.illegal = 1'b1;
      endcase
      if (d.rd == 5'd0) d.rd_we = 1'b0;
      return d;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          r;
      w = $urandom;
      r = $urandom_range(0, 19);
      if (r == 0) begin
         w = 32'h0000_0073;
      end else if (r == 1) begin
         w = 32'h0010_0073;
      end else if (r < 17) begin
         w[6:0] = ops[$urandom_range(0, 10)];
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'b0000000;
            1: w[31:25] = 7'b0100000;
            2: w[31:25] = 7'b0000001;
            default: ;
         endcase
      end
      return w;
   endfunction

   // Drive one cycle of stimulus on both DUTs and advance the reference model
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      logic acc;
      logic drn;
      ent_t e;
      bus0.in_valid_i = v;   bus1.in_valid_i = v;
      bus0.in_instr_i = ins; bus1.in_instr_i = ins;
      bus0.in_pc_i    = pc;  bus1.in_pc_i    = pc;
      bus0.out_ready_i = rdy; bus1.out_ready_i = rdy;
      bus0.flush_i    = fl;  bus1.flush_i    = fl;
      if (rst) begin
         q0.delete(); q1.delete(); cnt0 = 0; cnt1 = 0;
      end else if (fl) begin
         q0.delete(); q1.delete();
      end else begin
         acc = v && (q0.size() < 2);
         drn = (q0.size() > 0) && rdy;
         if (drn) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
         end
         if (acc) begin
            e.pc = pc; e.dec = exp_dec(ins, 1'b0); q0.push_back(e);
            if (e.dec.illegal && cnt0 < 65535) cnt0++;
            e.dec = exp_dec(ins, 1'b1); q1.push_back(e);
            if (e.dec.illegal && cnt1 < 7) cnt1++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle(1'b1, 32'h003100B3, 32'h10, 1'b0, 1'b0);
      cycle(1'b1, 32'h0020A063, 32'h14, 1'b0, 1'b0);
      checks++; if (bus0.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus0.out_valid_o); end
      checks++; if (bus0.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus0.in_ready_o); end
      checks++; if (bus0.out_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus0.out_pc_o); end
      checks++; if (bus0.out_dec_o !== '0) begin errors++; $display("FAIL reset_dec: got %h want 0", bus0.out_dec_o); end
      checks++; if (bus0.illegal_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus0.illegal_cnt_o); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      cycle(1'b1, 32'h003100B3, 32'h1000, 1'b1, 1'b0);
      checks++; if (bus0.out_valid_o !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", bus0.out_valid_o); end
      checks++; if (bus0.out_pc_o !== 32'h1000) begin errors++; $display("FAIL add_pc: got %h want 1000", bus0.out_pc_o); end
      checks++; if (bus0.out_dec_o.is_op !== 1'b1) begin errors++; $display("FAIL add_is_op: got %b want 1", bus0.out_dec_o.is_op); end
      checks++; if (bus0.out_dec_o.rd !== 5'd1) begin errors++; $display("FAIL add_rd: got %0d want 1", bus0.out_dec_o.rd); end
      checks++; if (bus0.out_dec_o.rs1 !== 5'd2) begin errors++; $display("FAIL add_rs1: got %0d want 2", bus0.out_dec_o.rs1); end
      checks++; if (bus0.out_dec_o.rs2 !== 5'd3) begin errors++; $display("FAIL add_rs2: got %0d want 3", bus0.out_dec_o.rs2); end
      checks++; if (bus0.out_dec_o.rd_we !== 1'b1) begin errors++; $display("FAIL add_rd_we: got %b want 1", bus0.out_dec_o.rd_we); end
      checks++; if (bus0.out_dec_o.illegal !== 1'b0) begin errors++; $display("FAIL add_illegal: got %b want 0", bus0.out_dec_o.illegal); end
   endtask

   task automatic test_imm_and_illegal();
      cycle(1'b1, 32'hFFF00093, 32'h1004, 1'b1, 1'b0);
      checks++; if (bus0.out_dec_o.imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm: got %h want ffffffff", bus0.out_dec_o.imm); end
      checks++; if (bus0.out_dec_o.imm_type !== IMM_I) begin errors++; $display("FAIL addi_imm_type: got %0d want %0d", bus0.out_dec_o.imm_type, IMM_I); end
      cycle(1'b1, 32'h0020A063, 32'h1008, 1'b1, 1'b0);
      checks++; if (bus0.out_dec_o.illegal !== 1'b1) begin errors++; $display("FAIL br010_illegal: got %b want 1", bus0.out_dec_o.illegal); end
      checks++; if (bus0.out_dec_o.is_branch !== 1'b0) begin errors++; $display("FAIL br010_cat: got %b want 0", bus0.out_dec_o.is_branch); end
      checks++; if (bus0.illegal_cnt_o !== 16'd1) begin errors++; $display("FAIL br010_cnt: got %0d want 1", bus0.illegal_cnt_o); end
   endtask

   task automatic test_muldiv();
      cycle(1'b1, 32'h023100B3, 32'h100C, 1'b1, 1'b0);
      checks++; if (bus0.out_dec_o.illegal !== 1'b1) begin errors++; $display("FAIL mul_noM_illegal: got %b want 1", bus0.out_dec_o.illegal); end
      checks++; if (bus1.out_dec_o.is_muldiv !== 1'b1) begin errors++; $display("FAIL mul_M_is_muldiv: got %b want 1", bus1.out_dec_o.is_muldiv); end
      checks++; if (bus1.out_dec_o.illegal !== 1'b0) begin errors++; $display("FAIL mul_M_illegal: got %b want 0", bus1.out_dec_o.illegal); end
      checks++; if (bus0.illegal_cnt_o !== 16'd2) begin errors++; $display("FAIL mul_noM_cnt: got %0d want 2", bus0.illegal_cnt_o); end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++; if (bus0.out_valid_o !== 1'b0) begin errors++; $display("FAIL mul_drained: got %b want 0", bus0.out_valid_o); end
   endtask

   task automatic test_backpressure();
      cycle(1'b1, 32'h00500113, 32'h2000, 1'b0, 1'b0);
      checks++; if (bus0.in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", bus0.in_ready_o); end
      cycle(1'b1, 32'h00600193, 32'h2004, 1'b0, 1'b0);
      checks++; if (bus0.in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", bus0.in_ready_o); end
      cycle(1'b1, 32'h00700213, 32'h2008, 1'b0, 1'b0);
      checks++; if (bus0.out_pc_o !== 32'h2000) begin errors++; $display("FAIL bp_hold_pc: got %h want 2000", bus0.out_pc_o); end
      checks++; if (bus0.out_dec_o !== exp_dec(32'h00500113, 1'b0)) begin errors++; $display("FAIL bp_hold_dec: got %h want %h", bus0.out_dec_o, exp_dec(32'h00500113, 1'b0)); end
      checks++; if (bus0.out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", bus0.out_valid_o); end
      cycle(1'b1, 32'h00700213, 32'h2008, 1'b1, 1'b0);
      checks++; if (bus0.out_pc_o !== 32'h2004) begin errors++; $display("FAIL bp_second_pc: got %h want 2004", bus0.out_pc_o); end
      checks++; if (bus0.in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", bus0.in_ready_o); end
      cycle(1'b1, 32'h00700213, 32'h2008, 1'b1, 1'b0);
      checks++; if (bus0.out_pc_o !== 32'h2008) begin errors++; $display("FAIL bp_third_pc: got %h want 2008", bus0.out_pc_o); end
      checks++; if (bus0.in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_skid_empty: got %b want 1", bus0.in_ready_o); end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++; if (bus0.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", bus0.out_valid_o); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 32'h00000013 | (32'(i + 1) << 7), 32'h4000 + 32'(4 * i), 1'b1, 1'b0);
         checks++; if (bus0.out_pc_o !== 32'h4000 + 32'(4 * i)) begin errors++; $display("FAIL b2b_pc%0d: got %h want %h", i, bus0.out_pc_o, 32'h4000 + 32'(4 * i)); end
         checks++; if (bus0.in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, bus0.in_ready_o); end
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_flush();
      cycle(1'b1, 32'h00500113, 32'h3000, 1'b0, 1'b0);
      cycle(1'b1, 32'h00600193, 32'h3004, 1'b0, 1'b0);
      checks++; if (bus0.in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_pre_full: got %b want 0", bus0.in_ready_o); end
      cycle(1'b1, 32'h0020A063, 32'h3008, 1'b1, 1'b1);
      checks++; if (bus0.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus0.out_valid_o); end
      checks++; if (bus0.in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus0.in_ready_o); end
      checks++; if (bus0.illegal_cnt_o !== 16'd2) begin errors++; $display("FAIL flush_cnt_full: got %0d want 2", bus0.illegal_cnt_o); end
      cycle(1'b1, 32'h00500113, 32'h300C, 1'b0, 1'b0);
      cycle(1'b1, 32'h0020A063, 32'h3010, 1'b0, 1'b1);
      checks++; if (bus0.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush1_valid: got %b want 0", bus0.out_valid_o); end
      checks++; if (bus0.illegal_cnt_o !== 16'd2) begin errors++; $display("FAIL flush1_cnt: got %0d want 2", bus0.illegal_cnt_o); end
      checks++; if (bus1.illegal_cnt_o !== 3'd1) begin errors++; $display("FAIL flush1_cnt_m: got %0d want 1", bus1.illegal_cnt_o); end
   endtask

   task automatic test_system();
      cycle(1'b1, 32'h00100073, 32'h5000, 1'b1, 1'b0);
      checks++; if (bus0.out_dec_o.illegal !== 1'b0) begin errors++; $display("FAIL ebreak_illegal: got %b want 0", bus0.out_dec_o.illegal); end
      checks++; if (bus0.out_dec_o.is_system !== 1'b1) begin errors++; $display("FAIL ebreak_system: got %b want 1", bus0.out_dec_o.is_system); end
      cycle(1'b1, 32'h00200073, 32'h5004, 1'b1, 1'b0);
      checks++; if (bus0.out_dec_o.illegal !== 1'b1) begin errors++; $display("FAIL sys200073_illegal: got %b want 1", bus0.out_dec_o.illegal); end
      checks++; if (bus0.illegal_cnt_o !== 16'd3) begin errors++; $display("FAIL sys200073_cnt: got %0d want 3", bus0.illegal_cnt_o); end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
         checks++; if (bus0.out_valid_o !== (q0.size() > 0)) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, bus0.out_valid_o, q0.size() > 0); end
         checks++; if (bus0.in_ready_o !== (q0.size() < 2)) begin errors++; $display("FAIL rnd_ready @%0d: got %b want %b", n, bus0.in_ready_o, q0.size() < 2); end
         checks++; if (bus0.illegal_cnt_o !== cnt0[15:0]) begin errors++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, bus0.illegal_cnt_o, cnt0); end
         checks++; if (bus1.illegal_cnt_o !== cnt1[2:0]) begin errors++; $display("FAIL rnd_cnt_m @%0d: got %0d want %0d", n, bus1.illegal_cnt_o, cnt1); end
         if (q0.size() > 0) begin
            checks++; if (bus0.out_pc_o !== q0[0].pc) begin errors++; $display("FAIL rnd_pc @%0d: got %h want %h", n, bus0.out_pc_o, q0[0].pc); end
            checks++; if (bus0.out_dec_o !== q0[0].dec) begin errors++; $display("FAIL rnd_dec @%0d: got %h want %h", n, bus0.out_dec_o, q0[0].dec); end
            checks++; if (bus1.out_dec_o !== q1[0].dec) begin errors++; $display("FAIL rnd_dec_m @%0d: got %h want %h", n, bus1.out_dec_o, q1[0].dec); end
         end
      end
      checks++; if (bus1.illegal_cnt_o !== 3'd7) begin errors++; $display("FAIL rnd_cnt_saturated: got %0d want 7", bus1.illegal_cnt_o); end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 32'h0020A063, 32'h6000, 1'b0, 1'b0);
      cycle(1'b1, 32'h00500113, 32'h6004, 1'b0, 1'b0);
      rst = 1'b1;
      cycle(1'b1, 32'h00600193, 32'h6008, 1'b0, 1'b0);
      checks++; if (bus0.out_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", bus0.out_valid_o); end
      checks++; if (bus0.in_ready_o !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b want 1", bus0.in_ready_o); end
      checks++; if (bus0.out_pc_o !== 32'h0) begin errors++; $display("FAIL mrst_pc: got %h want 0", bus0.out_pc_o); end
      checks++; if (bus0.out_dec_o !== '0) begin errors++; $display("FAIL mrst_dec: got %h want 0", bus0.out_dec_o); end
      checks++; if (bus0.illegal_cnt_o !== 16'd0) begin errors++; $display("FAIL mrst_cnt: got %0d want 0", bus0.illegal_cnt_o); end
      checks++; if (bus1.illegal_cnt_o !== 3'd0) begin errors++; $display("FAIL mrst_cnt_m: got %0d want 0", bus1.illegal_cnt_o); end
      rst = 1'b0;
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   initial begin
      bus0.in_valid_i = 1'b0; bus1.in_valid_i = 1'b0;
      bus0.in_instr_i = '0;   bus1.in_instr_i = '0;
      bus0.in_pc_i    = '0;   bus1.in_pc_i    = '0;
      bus0.out_ready_i = 1'b0; bus1.out_ready_i = 1'b0;
      bus0.flush_i    = 1'b0; bus1.flush_i    = 1'b0;
      @(negedge clk);
      test_reset();
      test_add();
      test_imm_and_illegal();
      test_muldiv();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_system();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_decode_stage.md
# riscv_decode_stage

Registered, parametrised RV32 decode stage between the fetch unit and the register-read/execute stage. It accepts one instruction word plus PC per valid/ready handshake and performs full field, immediate and category decode. Legality checking goes down to funct3/funct7 level, with optional M and Zicsr support. The result is presented one cycle later through a two-entry skid buffer, so upstream ready never depends combinationally on downstream ready. A saturating counter tracks accepted illegal instructions for debug.

## Interface
Parameters:
- ENABLE_M, 0: when 1, OP with funct7=0000001 (MUL..REMU) is legal and flagged is_muldiv.
- ENABLE_CSR, 1: when 1, SYSTEM funct3 ∈ {001,010,011,101,110,111} is legal and flagged is_csr.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous pipeline flush.
- in_valid_i  in  1  upstream instruction valid.
- in_ready_o  out  1  stage can accept an instruction this cycle.
- in_instr_i  in  32  instruction word.
- in_pc_i  in  32  instruction PC.
- out_valid_o  out  1  decoded instruction valid.
- out_ready_i  in  1  downstream accepts the decoded instruction.
- out_pc_o  out  32  PC of the presented instruction.
- out_dec_o  out  dec_t  decoded bundle: opcode, rd, rs1, rs2, funct3, funct7, imm (selected per format), imm_type, category one-hots, rd_we, rs1_used, rs2_used, illegal.
- illegal_cnt_o  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Decode is combinational on in_instr_i. The result is captured on acceptance (in_valid_i & in_ready_o & !flush_i).
- Immediate selection follows the format:
  - I: LOAD, JALR, OP_IMM.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - OP, SYSTEM and FENCE: imm = 0, imm_type = IMM_NONE.
  - All immediates are sign-extended to 32 bits. U-type has its low 12 bits zero.
- rd_we = 1 for LOAD, JAL, JALR, LUI, AUIPC, OP, OP_IMM and CSR ops; forced to 0 when rd = x0 or illegal.
- illegal = 1 when any of the following holds:
  - instr[1:0] ≠ 11.
  - Unknown opcode.
  - LOAD funct3 ∉ {000,001,010,100,101}.
  - STORE funct3 ∉ {000,001,010}.
  - BRANCH funct3 ∈ {010,011}.
  - JALR funct3 ≠ 000.
  - OP funct7 ∉ {0000000, 0100000 only with funct3 000/101, 0000001 only if ENABLE_M}.
  - OP_IMM funct3=001 with funct7 ≠ 0000000.
  - OP_IMM funct3=101 with funct7 ∉ {0000000,0100000}.
  - FENCE funct3 ∉ {000,001}.
  - SYSTEM funct3=000 with instr ∉ {0x00000073 ECALL, 0x00100073 EBREAK}.
  - SYSTEM funct3=100.
  - SYSTEM CSR funct3 when ENABLE_CSR=0.
- When illegal = 1, all category one-hots are 0 and is_illegal = 1. Fields are still passed through.
- Buffering uses a main register and a skid register:
  - If the main register is empty or draining (out_ready_i), an accepted instruction loads main.
  - Otherwise it loads skid.
  - On drain, skid moves into main.
  - in_ready_o = !skid_valid, registered.
- illegal_cnt_o increments by 1 on each accepted illegal instruction and saturates at 2^CNT_W−1. flush_i does not clear it.

## Timing
- Latency 1 cycle: an instruction accepted at edge N gives out_valid_o = 1 after edge N.
- Throughput 1 instruction/cycle while out_ready_i = 1.
- out_valid_o, out_pc_o and out_dec_o are stable while out_valid_o & !out_ready_i; order is preserved.
- Full: both registers valid, so in_ready_o = 0. It returns to 1 the cycle after the first drain.
- Accept and drain in the same cycle with one entry held: main is replaced, skid stays empty.
- flush_i: the next cycle main and skid are invalid and in_ready_o = 1. A same-cycle input is dropped and not counted. flush_i wins over simultaneous accept or drain.
- Reset, mid-operation included:
  - out_valid_o = 0, in_ready_o = 1.
  - out_pc_o = 0, out_dec_o = all zeros.
  - illegal_cnt_o = 0, skid empty.

## Structure
- Package riscv_pkg holds:
  - Opcode localparams.
  - imm_type_e enum: IMM_NONE, I, S, B, U, J.
  - dec_t packed struct.
  - Function legal funct3/funct7 tables.
- Sub-module riscv_decode_comb: purely combinational instr → dec_t, parametrised by ENABLE_M/ENABLE_CSR.
- The top level holds the skid buffer, the flush logic and the counter.

## Test plan
- 0x003100B3 (add x1,x2,x3), out_ready_i=1 → next cycle out_valid_o=1, is_op=1, rd=1, rs1=2, rs2=3, rd_we=1, illegal=0.
- 0xFFF00093 (addi x1,x0,−1) → imm=0xFFFFFFFF, imm_type=I. 0x0020A063 (BRANCH funct3=010) → illegal=1, illegal_cnt_o=1.
- 0x023100B3 (mul): with ENABLE_M=0 → illegal=1; with ENABLE_M=1 → is_muldiv=1, illegal=0.
- Hold out_ready_i=0 and send 3 instructions → first two are accepted, in_ready_o=0 at the third, and outputs stay stable. Release → instructions emerge in order, one per cycle.
- Assert flush_i with both entries full and in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1, counter unchanged.
- Feed 0x00100073 (EBREAK) → legal. Feed 0x00200073 → illegal. Raise rst_i mid-stream → all outputs return to their reset values.
